// File: rtl/rv32_multicycle_hs.sv
// rv32_multicycle_hs -- multicycle RV32I/RV32E core with a single
// request/ready memory port.
//
// Parameters:
//   RESET_PC  PC loaded while reset is high
//   NREGS     32 (RV32I) or 16 (RV32E); x16..x31 references halt the core
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   mem_addr/mem_wdata    byte address and lane-replicated store data
//   mem_wmask/mem_we      store byte enables (0 on reads) and write qualifier
//   mem_req               request pending (FETCH and MEM states only)
//   mem_rdata/mem_ready   read data and completion strobe
//   halted                core is parked in HALT until reset
//   dbg_state             current FSM state encoding (debug)
// Optional feature: define RV32_MUL_EN to add MUL (iterative shift-add,
// 32 cycles in MULT). Without it every funct7=0000001 OP instruction halts.
//
// Handshake: a request is raised with mem_req=1 and its address, data, mask
// and write qualifier stay constant until the rising edge at which
// mem_ready=1; that edge completes it. mem_ready is ignored while mem_req=0.
module rv32_multicycle_hs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_we,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        halted,
  output logic [2:0]  dbg_state
);
  localparam int RW = (NREGS == 16) ? 4 : 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
`ifdef RV32_MUL_EN
    S_MULT    = 3'd4,
`endif
    S_HALT    = 3'd5
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, ir, rs1_v, rs2_v, ls_addr, st_wdata;
  logic [3:0]  st_wmask;
  logic        st_q;
  logic [2:0]  ld_f3;
  logic [4:0]  rd_q;
  logic [31:0] regs [0:NREGS-1];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc_plus4;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign f3       = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign f7       = ir[31:25];
  assign imm_i    = {{20{ir[31]}}, ir[31:20]};
  assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u    = {ir[31:12], 12'b0};
  assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign pc_plus4 = pc + 32'd4;

  function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  alu = alt ? (a - b) : (a + b);
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'b0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

`ifdef RV32_MUL_EN
  logic [31:0] mul_a, mul_b, mul_acc, mul_sum;
  logic [4:0]  mul_cnt;
  logic        ex_mul;
  // Partial sum including the current multiplier bit; on the 32nd cycle
  // this is the final product.
  assign mul_sum = mul_acc + (mul_b[0] ? mul_a : 32'b0);
`endif

  // EXECUTE decode: results, next PC, memory op set-up and halt detection.
  logic        ex_halt, ex_wb, ex_mem, ex_store, br_take;
  logic        use_rd, use_rs1, use_rs2;
  logic [31:0] ex_wb_val, ex_pc, ex_addr, ex_wdata;
  logic [3:0]  ex_wmask;

  always_comb begin
    case (f3)
      3'b000:  br_take = (rs1_v == rs2_v);
      3'b001:  br_take = (rs1_v != rs2_v);
      3'b100:  br_take = ($signed(rs1_v) <  $signed(rs2_v));
      3'b101:  br_take = ($signed(rs1_v) >= $signed(rs2_v));
      3'b110:  br_take = (rs1_v <  rs2_v);
      3'b111:  br_take = (rs1_v >= rs2_v);
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    ex_halt   = 1'b0;
    ex_wb     = 1'b0;
    ex_mem    = 1'b0;
    ex_store  = 1'b0;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    ex_wb_val = 32'b0;
    ex_pc     = pc_plus4;
    ex_addr   = rs1_v + imm_i;
    ex_wdata  = rs2_v;
    ex_wmask  = 4'b0000;
`ifdef RV32_MUL_EN
    ex_mul    = 1'b0;
`endif
    case (opcode)
      OP_LUI:   begin use_rd = 1'b1; ex_wb = 1'b1; ex_wb_val = imm_u; end
      OP_AUIPC: begin use_rd = 1'b1; ex_wb = 1'b1; ex_wb_val = pc + imm_u; end
      OP_JAL: begin
        use_rd = 1'b1; ex_wb = 1'b1; ex_wb_val = pc_plus4; ex_pc = pc + imm_j;
      end
      OP_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; ex_wb = 1'b1; ex_wb_val = pc_plus4;
        ex_pc = {ex_addr[31:1], 1'b0};
        if (f3 != 3'b000) ex_halt = 1'b1;
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        if (f3 == 3'b010 || f3 == 3'b011) ex_halt = 1'b1;
        else if (br_take) ex_pc = pc + imm_b;
      end
      OP_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; ex_mem = 1'b1;
        case (f3)
          3'b000, 3'b100: ;
          3'b001, 3'b101: if (ex_addr[0]) ex_halt = 1'b1;
          3'b010:         if (ex_addr[1:0] != 2'b00) ex_halt = 1'b1;
          default:        ex_halt = 1'b1;
        endcase
      end
      OP_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; ex_mem = 1'b1; ex_store = 1'b1;
        ex_addr = rs1_v + imm_s;
        case (f3)
          3'b000: begin
            ex_wmask = 4'b0001 << ex_addr[1:0];
            ex_wdata = {4{rs2_v[7:0]}};
          end
          3'b001: begin
            ex_wmask = ex_addr[1] ? 4'b1100 : 4'b0011;
            ex_wdata = {2{rs2_v[15:0]}};
            if (ex_addr[0]) ex_halt = 1'b1;
          end
          3'b010: begin
            ex_wmask = 4'b1111;
            if (ex_addr[1:0] != 2'b00) ex_halt = 1'b1;
          end
          default: ex_halt = 1'b1;
        endcase
      end
      OP_IMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; ex_wb = 1'b1;
        ex_wb_val = alu(f3, (f3 == 3'b101) && ir[30], rs1_v, imm_i);
        if (f3 == 3'b001 && f7 != 7'b0000000) ex_halt = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) ex_halt = 1'b1;
      end
      OP_REG: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; ex_wb = 1'b1;
        ex_wb_val = alu(f3, ir[30], rs1_v, rs2_v);
        if (f7 == 7'b0000000) ;
        else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ;
`ifdef RV32_MUL_EN
        else if (f7 == 7'b0000001 && f3 == 3'b000) begin
          ex_wb  = 1'b0;
          ex_mul = 1'b1;
        end
`endif
        else ex_halt = 1'b1;
      end
      default: ex_halt = 1'b1;   // SYSTEM (ECALL/EBREAK) and unknown opcodes
    endcase
    if (NREGS == 16 && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4])))
      ex_halt = 1'b1;
  end

  // Load lane extraction from the addressed byte/halfword.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val, ld_shift;
  assign ld_shift = mem_rdata >> {ls_addr[1:0], 3'b000};
  assign ld_byte  = ld_shift[7:0];
  assign ld_half  = ls_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (ld_f3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'b0, ld_byte};
      3'b101:  ld_val = {16'b0, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  // Register file write port; reset suppresses any in-flight writeback.
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rd_q;
    rf_wdata = ld_val;
    case (state)
      S_EXECUTE: if (!ex_halt && ex_wb) begin
        rf_we = 1'b1; rf_waddr = rd; rf_wdata = ex_wb_val;
      end
      S_MEM: if (mem_ready && !st_q) rf_we = 1'b1;
`ifdef RV32_MUL_EN
      S_MULT: if (mul_cnt == 5'd31) begin rf_we = 1'b1; rf_wdata = mul_sum; end
`endif
      default: ;
    endcase
    if (reset || rf_waddr == 5'd0) rf_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rf_we) regs[rf_waddr[RW-1:0]] <= rf_wdata;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:   if (mem_ready) state_n = S_DECODE;
      S_DECODE:  state_n = S_EXECUTE;
      S_EXECUTE: begin
        if (ex_halt)     state_n = S_HALT;
        else if (ex_mem) state_n = S_MEM;
`ifdef RV32_MUL_EN
        else if (ex_mul) state_n = S_MULT;
`endif
        else             state_n = S_FETCH;
      end
      S_MEM:     if (mem_ready) state_n = S_FETCH;
`ifdef RV32_MUL_EN
      S_MULT:    if (mul_cnt == 5'd31) state_n = S_FETCH;
`endif
      default:   state_n = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      st_q     <= 1'b0;
      st_wmask <= 4'b0000;
      st_wdata <= 32'b0;
    end else begin
      state <= state_n;
      case (state)
        S_FETCH:  if (mem_ready) ir <= mem_rdata;
        S_DECODE: begin
          rs1_v <= (rs1 == 5'd0) ? 32'b0 : regs[rs1[RW-1:0]];
          rs2_v <= (rs2 == 5'd0) ? 32'b0 : regs[rs2[RW-1:0]];
        end
        S_EXECUTE: if (!ex_halt) begin
          pc       <= ex_pc;
          ls_addr  <= ex_addr;
          st_wdata <= ex_wdata;
          st_wmask <= ex_wmask;
          st_q     <= ex_store;
          ld_f3    <= f3;
          rd_q     <= rd;
`ifdef RV32_MUL_EN
          mul_a    <= rs1_v;
          mul_b    <= rs2_v;
          mul_acc  <= 32'b0;
          mul_cnt  <= 5'd0;
`endif
        end
`ifdef RV32_MUL_EN
        S_MULT: begin
          mul_acc <= mul_sum;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt + 5'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign mem_req   = !reset && (state == S_FETCH || state == S_MEM);
  assign mem_addr  = (state == S_MEM) ? ls_addr : pc;
  assign mem_we    = mem_req && (state == S_MEM) && st_q;
  assign mem_wmask = mem_we ? st_wmask : 4'b0000;
  assign mem_wdata = st_wdata;
  assign halted    = !reset && (state == S_HALT);
  assign dbg_state = state;
endmodule

// File: tb/tb_rv32_multicycle_hs.sv
// tb_rv32_multicycle_hs -- directed bench for rv32_multicycle_hs.
// A small memory responder serves requests with a programmable number of
// wait states, records every store, and checks that a waiting request is
// held stable. Register results are observed in the DUT register file.
module tb_rv32_multicycle_hs;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_we, mem_req, mem_ready, halted;
  logic [2:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  int wait_cycles = 0;
  logic idle_ready = 1'b0;
  int n_data = 0;
  int n_store = 0;
  int mult_cycles = 0;

  logic [31:0] mem [0:4095];
  logic [31:0] st_addr_q[$];
  logic [31:0] st_wdata_q[$];
  logic [3:0]  st_mask_q[$];

  rv32_multicycle_hs #(.RESET_PC(32'h0000_0100), .NREGS(32)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_we(mem_we), .mem_req(mem_req), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .halted(halted), .dbg_state(dbg_state)
  );

  // Clock / timeout
  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder (drives inputs at negedge, DUT samples at posedge)
  initial begin
    int cnt;
    logic pend;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_mask;
    logic        p_we;
    cnt = 0; pend = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    p_addr = 0; p_wdata = 0; p_mask = 0; p_we = 0;
    forever begin
      @(negedge clk);
      if (pend && mem_req && !reset)
        chk("req_stable", {mem_addr ^ p_addr, mem_wdata ^ p_wdata} == 64'h0
                          && mem_wmask == p_mask && mem_we == p_we ? 32'd1 : 32'd0, 32'd1);
      if (mem_req && !reset) begin
        if (cnt >= wait_cycles) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr[13:2]];
          cnt = 0; pend = 1'b0;
          if (mem_addr >= 32'h1000) n_data++;
          if (mem_we) begin
            n_store++;
            st_addr_q.push_back(mem_addr);
            st_wdata_q.push_back(mem_wdata);
            st_mask_q.push_back(mem_wmask);
            for (int b = 0; b < 4; b++)
              if (mem_wmask[b]) mem[mem_addr[13:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          end
        end else begin
          mem_ready = 1'b0;
          cnt++; pend = 1'b1;
          p_addr = mem_addr; p_wdata = mem_wdata; p_mask = mem_wmask; p_we = mem_we;
        end
      end else begin
        mem_ready = idle_ready;
        cnt = 0; pend = 1'b0;
      end
      if (dbg_state == 3'd4) mult_cycles++;
    end
  end

  // Driver tasks
  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    mem[addr[13:2]] = w;
  endtask

  task automatic restart(input string tag);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_rst_halted"}, 32'(halted), 32'd0);
    chk({tag, "_rst_req"}, 32'(mem_req), 32'd0);
    n_data = 0; n_store = 0; mult_cycles = 0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int limit);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(halted), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (mem_req !== 1'b0) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    // Program A: ALU, loads, stores, branches and jumps with 3 wait states
    clear_mem();
    put(32'h100, 32'h00500093);  // addi x1,x0,5
    put(32'h104, 32'h00700593);  // addi x11,x0,7
    put(32'h108, 32'h00001137);  // lui  x2,1
    put(32'h10C, 32'h0AB00193);  // addi x3,x0,0xAB
    put(32'h110, 32'h00211203);  // lh   x4,2(x2)
    put(32'h114, 32'h003101A3);  // sb   x3,3(x2)
    put(32'h118, 32'h00012303);  // lw   x6,0(x2)
    put(32'h11C, 32'h00314383);  // lbu  x7,3(x2)
    put(32'h120, 32'h00310403);  // lb   x8,3(x2)
    put(32'h124, 32'h003084B3);  // add  x9,x1,x3
    put(32'h128, 32'h40308533);  // sub  x10,x1,x3
    put(32'h12C, 32'h00108463);  // beq  x1,x1,+8
    put(32'h130, 32'h00100593);  // addi x11,x0,1 (skipped)
    put(32'h134, 32'h0080066F);  // jal  x12,+8
    put(32'h138, 32'h00200593);  // addi x11,x0,2 (skipped)
    put(32'h13C, 32'h00311323);  // sh   x3,6(x2)
    put(32'h140, 32'h151006E7);  // jalr x13,0x151(x0)
    put(32'h144, 32'h00300593);  // addi x11,x0,3 (skipped)
    put(32'h150, 32'h40455713);  // srai x14,x10,4
    put(32'h154, 32'h0030B7B3);  // sltu x15,x1,x3
    put(32'h158, 32'h00000073);  // ecall
    put(32'h1000, 32'h8001_0000);
    wait_cycles = 3;
    idle_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", mem_addr, 32'h0000_0100);

    wait_halt("a_halt", 3000);
    check_idle("a_idle");
    chk("x1_addi", dut.regs[1], 32'h0000_0005);
    chk("x2_lui", dut.regs[2], 32'h0000_1000);
    chk("x3_addi", dut.regs[3], 32'h0000_00AB);
    chk("x4_lh", dut.regs[4], 32'hFFFF_8001);
    chk("x6_lw", dut.regs[6], 32'hAB01_0000);
    chk("x7_lbu", dut.regs[7], 32'h0000_00AB);
    chk("x8_lb", dut.regs[8], 32'hFFFF_FFAB);
    chk("x9_add", dut.regs[9], 32'h0000_00B0);
    chk("x10_sub", dut.regs[10], 32'hFFFF_FF5A);
    chk("x11_skips", dut.regs[11], 32'h0000_0007);
    chk("x12_jal", dut.regs[12], 32'h0000_0138);
    chk("x13_jalr", dut.regs[13], 32'h0000_0144);
    chk("x14_srai", dut.regs[14], 32'hFFFF_FFF5);
    chk("x15_sltu", dut.regs[15], 32'h0000_0001);
    chk("store_count", 32'(st_addr_q.size()), 32'd2);
    if (st_addr_q.size() == 2) begin
      chk("sb_addr", st_addr_q[0], 32'h0000_1003);
      chk("sb_mask", 32'(st_mask_q[0]), 32'h8);
      chk("sb_lane", 32'(st_wdata_q[0][31:24]), 32'hAB);
      chk("sb_wdata", st_wdata_q[0], 32'hABAB_ABAB);
      chk("sh_addr", st_addr_q[1], 32'h0000_1006);
      chk("sh_mask", 32'(st_mask_q[1]), 32'hC);
      chk("sh_wdata", st_wdata_q[1], 32'h00AB_00AB);
    end

    // Program B: misaligned word load halts, rd untouched, no data request
    clear_mem();
    put(32'h100, 32'h00001137);  // lui  x2,1
    put(32'h104, 32'h00900293);  // addi x5,x0,9
    put(32'h108, 32'h00212283);  // lw   x5,2(x2)
    wait_cycles = 0;
    idle_ready = 1'b0;
    restart("b");
    wait_halt("b_halt", 200);
    check_idle("b_idle");
    chk("b_x5_kept", dut.regs[5], 32'h0000_0009);
    chk("b_no_data", 32'(n_data), 32'd0);

    // Program C: ECALL halts after earlier writeback
    clear_mem();
    put(32'h100, 32'h01100313);  // addi x6,x0,0x11
    put(32'h104, 32'h00000073);  // ecall
    restart("c");
    wait_halt("c_halt", 200);
    chk("c_x6", dut.regs[6], 32'h0000_0011);

    // Program D: MUL (completes in 32 MULT cycles, or halts when absent)
    clear_mem();
    put(32'h100, 32'hFFF00093);  // addi x1,x0,-1
    put(32'h104, 32'h00300113);  // addi x2,x0,3
    put(32'h108, 32'h05500293);  // addi x5,x0,0x55
    put(32'h10C, 32'h022082B3);  // mul  x5,x1,x2
    put(32'h110, 32'h00000073);  // ecall
    restart("d");
    wait_halt("d_halt", 500);
`ifdef RV32_MUL_EN
    chk("d_mul_x5", dut.regs[5], 32'hFFFF_FFFD);
    chk("d_mult_cycles", 32'(mult_cycles), 32'd32);
`else
    chk("d_mul_x5", dut.regs[5], 32'h0000_0055);
    chk("d_mult_cycles", 32'(mult_cycles), 32'd0);
`endif

    // Program E: misaligned word store halts without any memory request
    clear_mem();
    put(32'h100, 32'h00001137);  // lui x2,1
    put(32'h104, 32'h002120A3);  // sw  x2,1(x2)
    restart("e");
    wait_halt("e_halt", 200);
    check_idle("e_idle");
    chk("e_no_data", 32'(n_data), 32'd0);
    chk("e_no_store", 32'(n_store), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
